// File: rtl/hd44780_rx.sv
// hd44780_rx - receive side of an HD44780-style character LCD bus.
//
// Samples lcd_e / lcd_rs / data through a synchronizer and accepts one
// transfer per falling edge of E. Instructions update the cursor address and
// display flags. Data writes land in a 2x16 character buffer, which is exposed
// on a registered read port. A clear instruction, and reset, fill the buffer
// with spaces over 32 clocks while busy is high.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   lcd_e          enable strobe; a transfer is taken on its falling edge
//   lcd_rs         register select (0 = instruction, 1 = data)
//   data[7:0]      LCD data bus
//   rd_addr[4:0]   buffer read index {line, column}
//   rd_data[7:0]   buffer[rd_addr], one clock of latency
//   cursor_addr    DDRAM address counter (AC)
//   disp_on, cursor_on, blink_on, two_line, entry_inc   decoded flags
//   busy           clear in progress; transfers are dropped
//   cmd_strobe     one-cycle pulse per accepted transfer
//   overrun        sticky, a transfer arrived while busy
module hd44780_rx #(
  parameter int SYNC_STAGES = 2  // must be at least 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic [7:0] data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] cursor_addr,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       entry_inc,
  output logic       busy,
  output logic       cmd_strobe,
  output logic       overrun
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Cursor moves with the two-line DDRAM wrap. Out-of-range addresses
  // 0x68-0x7F wrap forward to 0x00.
  function automatic logic [6:0] cur_inc(input logic [6:0] a);
    if (a == 7'h27)       return 7'h40;
    else if (a >= 7'h67)  return 7'h00;
    else                  return a + 7'd1;
  endfunction

  // Out-of-range addresses 0x28-0x3F fall back to the end of line one.
  function automatic logic [6:0] cur_dec(input logic [6:0] a);
    if (a == 7'h00)                               return 7'h67;
    else if (a == 7'h40)                          return 7'h27;
    else if ((a >= 7'h28) && (a <= 7'h3F))        return 7'h27;
    else                                          return a - 7'd1;
  endfunction

  // Stage: input synchronizers and E delay flop
  logic [SYNC_STAGES-1:0] e_sync_q;
  logic [SYNC_STAGES-1:0] rs_sync_q;
  logic [7:0]             data_sync_q [SYNC_STAGES];
  logic                   e_dly_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      e_sync_q  <= '0;
      rs_sync_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= '0;
      e_dly_q   <= 1'b0;
    end else begin
      e_sync_q       <= {e_sync_q[SYNC_STAGES-2:0], lcd_e};
      rs_sync_q      <= {rs_sync_q[SYNC_STAGES-2:0], lcd_rs};
      data_sync_q[0] <= data;
      for (int i = 1; i < SYNC_STAGES; i++) data_sync_q[i] <= data_sync_q[i-1];
      e_dly_q        <= e_sync_q[SYNC_STAGES-1];
    end
  end

  // rs/data come from the same sync stage as E, so they are the values held
  // while E was still high.
  logic       xfer;
  logic       xrs;
  logic [7:0] xd;
  assign xfer = e_dly_q & ~e_sync_q[SYNC_STAGES-1];
  assign xrs  = rs_sync_q[SYNC_STAGES-1];
  assign xd   = data_sync_q[SYNC_STAGES-1];

  // Stage: decode and control state
  state_t     state_q, state_d;
  logic [4:0] clr_idx_q, clr_idx_d;
  logic [6:0] cursor_q, cursor_d;
  logic       disp_q, disp_d;
  logic       curs_q, curs_d;
  logic       blink_q, blink_d;
  logic       two_q, two_d;
  logic       inc_q, inc_d;
  logic       strobe_q, strobe_d;
  logic       ovr_q, ovr_d;
  logic       wr_en;
  logic [4:0] wr_idx;
  logic [7:0] wr_data;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    cursor_d  = cursor_q;
    disp_d    = disp_q;
    curs_d    = curs_q;
    blink_d   = blink_q;
    two_d     = two_q;
    inc_d     = inc_q;
    strobe_d  = 1'b0;
    ovr_d     = ovr_q;
    wr_en     = 1'b0;
    wr_idx    = clr_idx_q;
    wr_data   = 8'h20;

    case (state_q)
      ST_CLEAR: begin
        wr_en     = 1'b1;
        clr_idx_d = clr_idx_q + 5'd1;
        if (clr_idx_q == 5'd31) state_d = ST_IDLE;
        if (xfer) ovr_d = 1'b1;
      end
      default: begin
        if (xfer) begin
          strobe_d = 1'b1;
          if (xrs) begin
            // Only columns 0-15 of each line are backed by the buffer.
            if (cursor_q[5:4] == 2'b00) begin
              wr_en   = 1'b1;
              wr_idx  = {cursor_q[6], cursor_q[3:0]};
              wr_data = xd;
            end
            cursor_d = inc_q ? cur_inc(cursor_q) : cur_dec(cursor_q);
          end else begin
            casez (xd)
              8'b1???????: cursor_d = xd[6:0];
              8'b01??????: begin end
              8'b001?????: two_d = xd[3];
              8'b0001????: begin
                if (!xd[3]) cursor_d = xd[2] ? cur_inc(cursor_q) : cur_dec(cursor_q);
              end
              8'b00001???: begin
                disp_d  = xd[2];
                curs_d  = xd[1];
                blink_d = xd[0];
              end
              8'b000001??: inc_d = xd[1];
              8'b0000001?: cursor_d = 7'h00;
              8'b00000001: begin
                cursor_d  = 7'h00;
                inc_d     = 1'b1;
                clr_idx_d = 5'd0;
                state_d   = ST_CLEAR;
              end
              default: begin end
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= 5'd0;
      cursor_q  <= 7'h00;
      disp_q    <= 1'b0;
      curs_q    <= 1'b0;
      blink_q   <= 1'b0;
      two_q     <= 1'b0;
      inc_q     <= 1'b1;
      strobe_q  <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      cursor_q  <= cursor_d;
      disp_q    <= disp_d;
      curs_q    <= curs_d;
      blink_q   <= blink_d;
      two_q     <= two_d;
      inc_q     <= inc_d;
      strobe_q  <= strobe_d;
      ovr_q     <= ovr_d;
    end
  end

  // Stage: character buffer and registered read port
  logic [7:0] mem_q [32];
  logic [7:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  // Reads the pre-write contents, so a same-cycle write returns the old value.
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= 8'h00;
    else     rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data     = rd_data_q;
  assign cursor_addr = cursor_q;
  assign disp_on     = disp_q;
  assign cursor_on   = curs_q;
  assign blink_on    = blink_q;
  assign two_line    = two_q;
  assign entry_inc   = inc_q;
  assign busy        = (state_q == ST_CLEAR);
  assign cmd_strobe  = strobe_q;
  assign overrun     = ovr_q;

endmodule

// File: tb/tb_hd44780_rx.sv
module tb_hd44780_rx;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lcd_e = 1'b0;
  logic       lcd_rs = 1'b0;
  logic [7:0] data = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;
  logic [6:0] cursor_addr;
  logic       disp_on, cursor_on, blink_on, two_line, entry_inc;
  logic       busy, cmd_strobe, overrun;

  hd44780_rx #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .data(data),
    .rd_addr(rd_addr), .rd_data(rd_data), .cursor_addr(cursor_addr),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .two_line(two_line), .entry_inc(entry_inc), .busy(busy),
    .cmd_strobe(cmd_strobe), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  int exp_cyc;
  int exp_q[$];   // expected cycle of each cmd_strobe, pushed when E falls

  string msg   = "FPGAs are fun!!!";
  string smile = ":-)";

  // Scoreboard consumer: every strobe must match the next pushed expectation.
  always @(negedge clk) begin
    if (cmd_strobe === 1'b1) begin
      strobe_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected at cycle %0d, required no strobe", cyc);
      end else begin
        exp_cyc = exp_q.pop_front();
        if (cyc !== exp_cyc) begin
          errors++;
          $display("FAIL strobe_timing got cycle %0d required %0d", cyc, exp_cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  // One transfer: E high for hi clocks, then low while rs/data stay stable.
  task automatic do_xfer(input logic rs_v, input logic [7:0] d, input int hi, input bit accept);
    @(posedge clk);
    #1;
    lcd_rs = rs_v;
    data   = d;
    lcd_e  = 1'b1;
    repeat (hi) @(posedge clk);
    #1;
    lcd_e = 1'b0;
    if (accept) exp_q.push_back(cyc + SYNC + 1);
    repeat (SYNC + 3) @(posedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic set_rd(input logic [4:0] a);
    @(posedge clk);
    #1;
    rd_addr = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b required 1", busy); end
    checks++; if (cmd_strobe !== 1'b0) begin errors++; $display("FAIL rst_strobe got %b required 0", cmd_strobe); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b required 0", overrun); end
    checks++; if (cursor_addr !== 7'h00) begin errors++; $display("FAIL rst_cursor got %h required 00", cursor_addr); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data got %h required 00", rd_data); end
    checks++; if (two_line !== 1'b0) begin errors++; $display("FAIL rst_two_line got %b required 0", two_line); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (busy && n < 100);
    checks++; if (n !== 32) begin errors++; $display("FAIL rst_busy_len got %0d required 32", n); end
    for (int i = 0; i < 32; i++) begin
      set_rd(5'(i));
      checks++;
      if (rd_data !== 8'h20) begin errors++; $display("FAIL rst_clear idx %0d got %h required 20", i, rd_data); end
    end
    checks++; if (disp_on !== 1'b0) begin errors++; $display("FAIL rst_disp_on got %b required 0", disp_on); end
    checks++; if (entry_inc !== 1'b1) begin errors++; $display("FAIL rst_entry_inc got %b required 1", entry_inc); end
  endtask

  task automatic test_driver_seq();
    strobe_cnt = 0;
    do_xfer(1'b0, 8'h38, 4, 1'b1);
    do_xfer(1'b0, 8'h0C, 4, 1'b1);
    do_xfer(1'b0, 8'h06, 4, 1'b1);
    do_xfer(1'b0, 8'h01, 4, 1'b1);
    wait_idle();
    do_xfer(1'b0, 8'h80, 4, 1'b1);
    for (int i = 0; i < 16; i++) do_xfer(1'b1, msg[i], 4, 1'b1);
    do_xfer(1'b0, 8'hC0, 4, 1'b1);
    for (int i = 0; i < 3; i++) do_xfer(1'b1, smile[i], 4, 1'b1);
    @(negedge clk);
    checks++; if (two_line !== 1'b1) begin errors++; $display("FAIL drv_two_line got %b required 1", two_line); end
    checks++; if (disp_on !== 1'b1) begin errors++; $display("FAIL drv_disp_on got %b required 1", disp_on); end
    checks++; if (cursor_on !== 1'b0) begin errors++; $display("FAIL drv_cursor_on got %b required 0", cursor_on); end
    checks++; if (blink_on !== 1'b0) begin errors++; $display("FAIL drv_blink_on got %b required 0", blink_on); end
    checks++; if (cursor_addr !== 7'h43) begin errors++; $display("FAIL drv_cursor got %h required 43", cursor_addr); end
    checks++; if (strobe_cnt !== 25) begin errors++; $display("FAIL drv_strobe_count got %0d required 25", strobe_cnt); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL drv_pending got %0d required 0", exp_q.size()); end
    for (int i = 0; i < 16; i++) begin
      set_rd(5'(i));
      checks++;
      if (rd_data !== msg[i]) begin errors++; $display("FAIL drv_line1 col %0d got %h required %h", i, rd_data, msg[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      set_rd(5'(16 + i));
      checks++;
      if (rd_data !== smile[i]) begin errors++; $display("FAIL drv_line2 col %0d got %h required %h", i, rd_data, smile[i]); end
    end
  endtask

  task automatic test_overrun();
    strobe_cnt = 0;
    @(negedge clk);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_initial got %b required 0", overrun); end
    do_xfer(1'b0, 8'h01, 4, 1'b1);
    repeat (3) @(posedge clk);
    do_xfer(1'b1, 8'h41, 4, 1'b0);
    @(negedge clk);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b required 1", overrun); end
    wait_idle();
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b required 1", overrun); end
    checks++; if (strobe_cnt !== 1) begin errors++; $display("FAIL ovr_strobe_count got %0d required 1", strobe_cnt); end
    checks++; if (cursor_addr !== 7'h00) begin errors++; $display("FAIL ovr_cursor got %h required 00", cursor_addr); end
    for (int i = 0; i < 32; i++) begin
      set_rd(5'(i));
      checks++;
      if (rd_data !== 8'h20) begin errors++; $display("FAIL ovr_buffer idx %0d got %h required 20", i, rd_data); end
    end
  endtask

  task automatic test_wrap();
    do_xfer(1'b0, 8'hA7, 4, 1'b1);
    do_xfer(1'b1, 8'h78, 4, 1'b1);
    @(negedge clk);
    checks++; if (cursor_addr !== 7'h40) begin errors++; $display("FAIL wrap_inc27 got %h required 40", cursor_addr); end
    set_rd(5'd7);
    checks++; if (rd_data !== 8'h20) begin errors++; $display("FAIL wrap_drop idx7 got %h required 20", rd_data); end
    set_rd(5'd16);
    checks++; if (rd_data !== 8'h20) begin errors++; $display("FAIL wrap_drop idx16 got %h required 20", rd_data); end
    do_xfer(1'b0, 8'h04, 4, 1'b1);
    do_xfer(1'b0, 8'hC0, 4, 1'b1);
    do_xfer(1'b1, 8'h79, 4, 1'b1);
    @(negedge clk);
    checks++; if (cursor_addr !== 7'h27) begin errors++; $display("FAIL wrap_dec40 got %h required 27", cursor_addr); end
    set_rd(5'd16);
    checks++; if (rd_data !== 8'h79) begin errors++; $display("FAIL wrap_write idx16 got %h required 79", rd_data); end
    do_xfer(1'b0, 8'h80, 4, 1'b1);
    do_xfer(1'b0, 8'h10, 4, 1'b1);
    @(negedge clk);
    checks++; if (cursor_addr !== 7'h67) begin errors++; $display("FAIL wrap_shl00 got %h required 67", cursor_addr); end
    do_xfer(1'b0, 8'h14, 4, 1'b1);
    @(negedge clk);
    checks++; if (cursor_addr !== 7'h00) begin errors++; $display("FAIL wrap_shr67 got %h required 00", cursor_addr); end
    do_xfer(1'b0, 8'hB0, 4, 1'b1);
    do_xfer(1'b0, 8'h10, 4, 1'b1);
    @(negedge clk);
    checks++; if (cursor_addr !== 7'h27) begin errors++; $display("FAIL wrap_shl30 got %h required 27", cursor_addr); end
    do_xfer(1'b0, 8'hFF, 4, 1'b1);
    do_xfer(1'b0, 8'h14, 4, 1'b1);
    @(negedge clk);
    checks++; if (cursor_addr !== 7'h00) begin errors++; $display("FAIL wrap_shr7f got %h required 00", cursor_addr); end
    do_xfer(1'b0, 8'h1C, 4, 1'b1);
    @(negedge clk);
    checks++; if (cursor_addr !== 7'h00) begin errors++; $display("FAIL wrap_dispshift got %h required 00", cursor_addr); end
  endtask

  task automatic test_read_timing();
    do_xfer(1'b0, 8'h06, 4, 1'b1);
    do_xfer(1'b0, 8'h85, 4, 1'b1);
    do_xfer(1'b1, 8'h5A, 4, 1'b1);
    set_rd(5'd21);
    checks++; if (rd_data !== 8'h20) begin errors++; $display("FAIL rd_idx21 got %h required 20", rd_data); end
    @(posedge clk);
    #1;
    rd_addr = 5'd5;
    @(negedge clk);
    checks++; if (rd_data !== 8'h20) begin errors++; $display("FAIL rd_latency_early got %h required 20", rd_data); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL rd_latency_one got %h required 5a", rd_data); end
    checks++; if (cursor_addr !== 7'h06) begin errors++; $display("FAIL rd_cursor got %h required 06", cursor_addr); end
  endtask

  task automatic test_short_pulse();
    strobe_cnt = 0;
    do_xfer(1'b0, 8'h0F, 1, 1'b1);
    @(negedge clk);
    checks++; if (disp_on !== 1'b1) begin errors++; $display("FAIL short_disp_on got %b required 1", disp_on); end
    checks++; if (cursor_on !== 1'b1) begin errors++; $display("FAIL short_cursor_on got %b required 1", cursor_on); end
    checks++; if (blink_on !== 1'b1) begin errors++; $display("FAIL short_blink_on got %b required 1", blink_on); end
    checks++; if (strobe_cnt !== 1) begin errors++; $display("FAIL short_strobe_count got %0d required 1", strobe_cnt); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL short_pending got %0d required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_driver_seq();
    test_overrun();
    test_wrap();
    test_read_timing();
    test_short_pulse();
    repeat (5) @(posedge clk);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL final_pending got %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hd44780_rx.md
Name: hd44780_rx

Overview:
- Receive-side model of the HD44780-style character LCD bus that our LCD_DISPLAY driver writes.
- Samples lcd_e, lcd_rs and data, accepts one transfer per falling edge of E, and decodes instructions.
- Maintains a 2x16 DDRAM character buffer, cursor and display flags, and exposes the buffer on a registered read port.
- Used as the on-chip loopback target for driver verification and as a display-mirror source for debug/VGA logic.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on lcd_e, lcd_rs and data (minimum 2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
lcd_e  input  1  LCD enable strobe; transfer on falling edge
lcd_rs  input  1  register select: 0 = instruction, 1 = data
data  input  8  LCD data bus
rd_addr  input  5  buffer read index: bit4 = line (0 first, 1 second), bits3:0 = column
rd_data  output  8  character at rd_addr, registered
cursor_addr  output  7  current DDRAM address (AC)
disp_on  output  1  display on flag (D)
cursor_on  output  1  cursor on flag (C)
blink_on  output  1  blink flag (B)
two_line  output  1  function-set N bit
entry_inc  output  1  entry mode I/D: 1 = increment
busy  output  1  clear in progress; transfers ignored
cmd_strobe  output  1  one-cycle pulse per accepted transfer
overrun  output  1  sticky: a transfer arrived while busy

Behaviour:
- Synchronization: lcd_e, lcd_rs and data each pass through SYNC_STAGES flops. Edge detection uses the last sync stage and one extra delay flop.
- A transfer is detected when delay = 1 and the sync output = 0. rs/data are taken from the sync stage values of the same cycle, i.e. as held while E was high.
- State update and cmd_strobe both occur on the clock edge that registers the detection, SYNC_STAGES+1 clocks after raw lcd_e falls.
- Transfer while busy=1: dropped, no cmd_strobe, overrun set to 1. overrun clears only on rst.
- Instruction decode (rs=0), highest set bit wins:
  - 0x80-0xFF set DDRAM address: cursor_addr = data[6:0].
  - 0x40-0x7F CGRAM address: accepted (cmd_strobe), no effect.
  - 0x20-0x3F function set: two_line = data[3].
  - 0x10-0x1F shift: if data[3]=0, move cursor by one (data[2]=1 right, else left) using the wrap rules below. If data[3]=1 (display shift), no effect.
  - 0x08-0x0F display control: disp_on = d[2], cursor_on = d[1], blink_on = d[0].
  - 0x04-0x07 entry mode: entry_inc = d[1]; d[0] ignored.
  - 0x02-0x03 return home: cursor_addr = 0.
  - 0x01 clear: cursor_addr = 0, entry_inc = 1, busy = 1, then CLEAR state.
  - 0x00: no effect.
- Data write (rs=1):
  - If cursor_addr is in 0x00-0x0F or 0x40-0x4F, write data to buffer index {cursor_addr[6], cursor_addr[3:0]}; otherwise drop the character.
  - Always advance the cursor.
- Cursor wrap: increment 0x27 -> 0x40, 0x67 -> 0x00; decrement 0x00 -> 0x67, 0x40 -> 0x27. All other moves are ±1.
- Out-of-range addresses set by an instruction (e.g. 0x30, 0x7F) are held as-is. The next increment from 0x68-0x7F wraps to 0x00; the next decrement from 0x28-0x3F goes to 0x27.
- FSM:
  - IDLE: decode transfers.
  - CLEAR: writes 0x20 to buffer[clr_idx], clr_idx 0..31, one per clock. Returns to IDLE after index 31; busy drops in the cycle IDLE is re-entered.
  - Clear lasts exactly 32 cycles.
- Reset (synchronous, dominates everything): while rst=1, FSM = CLEAR, clr_idx = 0, busy = 1. All other outputs reset as follows:
  - cursor_addr = 0, disp_on = 0, cursor_on = 0, blink_on = 0, two_line = 0.
  - entry_inc = 1, cmd_strobe = 0, overrun = 0, rd_data = 0.
  - Synchronizer and delay flops = 0.
- Post-reset: the 32-cycle clear runs, so busy falls 32 clocks after rst deasserts and the buffer holds all 0x20.
- Reset mid-clear restarts the clear from index 0.
- rd_data = buffer[rd_addr], registered, 1-cycle latency.
  - A same-cycle write to the read location returns the old value.
  - rd_data is valid during CLEAR; it shows the old or space value depending on progress.
- An E that is high during reset and falls after release produces no transfer if busy; overrun is set.

Test Plan:
- Reset held 3 cycles, then release and wait -> busy = 1 for exactly 32 clocks after release; afterwards rd_data = 0x20 for all 32 rd_addr values; disp_on = 0; entry_inc = 1.
- Driver sequence 38,0C,06,01,80 (rs=0), then "FPGAs are fun!!!" (rs=1), then C0 (rs=0), then ":-)" (rs=1), each with E high for ≥ 4 clocks:
  - Second-line entries 0-2 = 3A, 2D, 29; first line reads "FPGAs are fun!!!".
  - two_line = 1, disp_on = 1, cursor_on = 0, blink_on = 0, cursor_addr = 0x43.
  - Exactly 25 cmd_strobe pulses, each SYNC_STAGES+1 clocks after E falls.
- Transfer of 0x41 (rs=1) issued 5 clocks after a 0x01 clear -> no cmd_strobe, overrun = 1 and stays 1, buffer all 0x20.
- Cursor wrap:
  - Set address 0x27, write 'x' -> cursor_addr = 0x40, buffer unchanged.
  - Entry mode 0x04, address 0x40, write 'y' -> buffer index 16 = 'y', cursor_addr = 0x27.
  - Address 0x00, instruction 0x10 -> cursor_addr = 0x67.
- Read timing: write 0x5A at address 0x05, then set rd_addr = 5 -> rd_data = 0x5A exactly one clock later. rd_addr = 21 gives 0x20.
- E pulse of exactly one clock with data = 0x0F, rs = 0 -> accepted; disp_on = cursor_on = blink_on = 1; one cmd_strobe.
